// File: rtl/pkt_ff_pkg.sv
// Shared types and helpers for the async packet FIFO: word layout, gray/binary
// conversion and synchronizer depth, used by both the read and write pointer stages.
package pkt_ff_pkg;

  localparam int SYNC_STAGES   = 2;
  localparam int PKT_FF_DATA_W = 32;
  // Conversions work on this width; narrower pointers are zero-extended in and truncated out.
  localparam int PKT_FF_MAX_W  = 32;

  typedef struct packed {
    logic                     sop;
    logic                     eop;
    logic [PKT_FF_DATA_W-1:0] data;
  } pkt_ff_word_t;

  function automatic logic [PKT_FF_MAX_W-1:0] bin2gray(input logic [PKT_FF_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PKT_FF_MAX_W-1:0] gray2bin(input logic [PKT_FF_MAX_W-1:0] gry);
    logic [PKT_FF_MAX_W-1:0] bin;
    bin[PKT_FF_MAX_W-1] = gry[PKT_FF_MAX_W-1];
    for (int i = PKT_FF_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gry[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/pkt_ff_sync.sv
// N-flop bit-vector synchronizer for gray-coded pointers crossing clock domains.
// Shared by the read side (write pointer in) and the write side (read pointer in).
module pkt_ff_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_sync [STAGES];

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/pkt_ff_rptr.sv
// Read-domain pointer/control stage of the async packet FIFO: syncs the committed
// write pointer, issues RAM reads and unloads words through a 2-entry output buffer.
module pkt_ff_rptr
  import pkt_ff_pkg::*;
#(
  parameter int PTR_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PTR_W-1:0]  wptr_cmt_gry,
  output logic [PTR_W-1:0]  rptr_gry,
  output logic              mem_rd_en,
  output logic [PTR_W-2:0]  mem_raddr,
  input  logic [DATA_W+1:0] mem_rdata,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_sop,
  output logic              rd_eop,
  output logic [DATA_W-1:0] rd_data,
  output logic              ff_empty,
  output logic [PTR_W-1:0]  ff_occ,
  output logic              pkt_err
);

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } word_t;

  logic [PTR_W-1:0] w_wgry_s;
  logic [PTR_W-1:0] w_wbin_s;
  logic [PTR_W-1:0] w_occ;
  logic             w_empty;
  logic             w_pop;
  logic             w_issue;
  logic [2:0]       w_ob_after;
  logic [PTR_W-1:0] w_rptr_nxt;
  word_t            w_rdata;
  word_t            w_head;

  logic [PTR_W-1:0] r_rptr_bin;
  logic [PTR_W-1:0] r_rptr_gry;
  logic             r_inflight;
  logic [1:0]       r_ob_cnt;
  logic             r_ob_rd;
  logic             r_ob_wr;
  word_t            r_ob_mem [2];
  logic             r_in_pkt;
  logic             r_pkt_err;
  logic             r_ff_empty;
  logic [PTR_W-1:0] r_ff_occ;

  pkt_ff_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (wptr_cmt_gry),
    .o_sync  (w_wgry_s)
  );

  assign w_wbin_s = PTR_W'(gray2bin(PKT_FF_MAX_W'(w_wgry_s)));
  assign w_occ    = w_wbin_s - r_rptr_bin;
  assign w_empty  = (w_occ == '0);
  assign w_pop    = rd_valid & rd_ready;

  // Issue only if the word will have a buffer slot once everything already in
  // flight has landed and this cycle's pop (if any) has left.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_ob_after = 3'(r_ob_cnt) + 3'(r_inflight) - 3'(w_pop);
    w_issue    = 1'b0;
    if (!w_empty && (w_ob_after < 3'd2)) w_issue = 1'b1;
  end

  assign w_rptr_nxt = r_rptr_bin + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr_bin <= '0;
      r_rptr_gry <= '0;
      r_inflight <= 1'b0;
      r_ff_empty <= 1'b1;
      r_ff_occ   <= '0;
    end else begin
      r_inflight <= w_issue;
      r_ff_empty <= w_empty;
      r_ff_occ   <= w_occ;
      if (w_issue) begin
        r_rptr_bin <= w_rptr_nxt;
        r_rptr_gry <= PTR_W'(bin2gray(PKT_FF_MAX_W'(w_rptr_nxt)));
      end
    end
  end

  assign w_rdata = mem_rdata;
  assign w_head  = r_ob_mem[r_ob_rd];

  // NOTE: the buffer storage is reset because its head drives rd_* directly and
  // those outputs must read zero out of reset; larger RAMs would not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ob_mem[0] <= '0;
      r_ob_mem[1] <= '0;
      r_ob_cnt    <= '0;
      r_ob_rd     <= 1'b0;
      r_ob_wr     <= 1'b0;
    end else begin
      if (r_inflight) begin
        r_ob_mem[r_ob_wr] <= w_rdata;
        r_ob_wr           <= ~r_ob_wr;
      end
      if (w_pop) r_ob_rd <= ~r_ob_rd;
      r_ob_cnt <= r_ob_cnt + 2'(r_inflight) - 2'(w_pop);
    end
  end

  // Framing monitor: observes popped words only, never alters the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_pkt  <= 1'b0;
      r_pkt_err <= 1'b0;
    end else begin
      r_pkt_err <= w_pop & (w_head.sop ? r_in_pkt : ~r_in_pkt);
      if (w_pop) begin
        if (w_head.eop)      r_in_pkt <= 1'b0;
        else if (w_head.sop) r_in_pkt <= 1'b1;
      end
    end
  end

  assign rptr_gry  = r_rptr_gry;
  assign mem_rd_en = w_issue;
  assign mem_raddr = r_rptr_bin[PTR_W-2:0];
  assign rd_valid  = (r_ob_cnt != 2'd0);
  assign rd_sop    = w_head.sop;
  assign rd_eop    = w_head.eop;
  assign rd_data   = w_head.data;
  assign ff_empty  = r_ff_empty;
  assign ff_occ    = r_ff_occ;
  assign pkt_err   = r_pkt_err;

endmodule

// File: tb/tb_pkt_ff_rptr.sv
// Self-checking bench for pkt_ff_rptr: the bench plays writer and RAM, and checks
// the read stream against a word queue plus a packet-framing model.
module tb_pkt_ff_rptr;

  localparam int PW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << (PW - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] wptr_cmt_gry = '0;
  logic [PW-1:0] rptr_gry;
  logic          mem_rd_en;
  logic [PW-2:0] mem_raddr;
  logic [DW+1:0] mem_rdata = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          rd_sop;
  logic          rd_eop;
  logic [DW-1:0] rd_data;
  logic          ff_empty;
  logic [PW-1:0] ff_occ;
  logic          pkt_err;

  always #5 clk = ~clk;

  pkt_ff_rptr #(.PTR_W(PW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wptr_cmt_gry (wptr_cmt_gry),
    .rptr_gry     (rptr_gry),
    .mem_rd_en    (mem_rd_en),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_sop       (rd_sop),
    .rd_eop       (rd_eop),
    .rd_data      (rd_data),
    .ff_empty     (ff_empty),
    .ff_occ       (ff_occ),
    .pkt_err      (pkt_err)
  );

  // Synchronous-read RAM: data appears one clock after the strobe.
  logic [DW+1:0] ram [DEPTH];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_raddr];

  logic [DW+1:0] exp_q[$];
  int  n_chk = 0, n_pass = 0;
  int  wr_cnt = 0, cmt_cnt = 0, pop_cnt = 0;
  bit  m_in_pkt = 1'b0, exp_err = 1'b0;
  int  tick_idx, n_issue, first_issue, n_valid, first_valid, last_valid, n_err_seen, max_occ;
  bit  hold_prev = 1'b0;
  logic [DW+1:0] hold_word = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic push_word(input bit sop, input bit eop, input logic [DW-1:0] d);
    ram[wr_cnt % DEPTH] = {sop, eop, d};
    exp_q.push_back({sop, eop, d});
    wr_cnt++;
  endtask

  task automatic commit();
    cmt_cnt      = wr_cnt;
    wptr_cmt_gry = gray(cmt_cnt);
  endtask

  task automatic clr_stats();
    tick_idx = 0; n_issue = 0; first_issue = -1; n_valid = 0;
    first_valid = -1; last_valid = -1; n_err_seen = 0; max_occ = 0;
  endtask

  // Called at a falling edge with inputs already driven; samples, scores, then
  // advances to the next falling edge.
  task automatic tick();
    logic [DW+1:0] w, e;
    #1;
    check("pkt_err", pkt_err, exp_err);
    if (pkt_err) n_err_seen++;
    exp_err = 1'b0;
    check("occ_bound", 64'(int'(ff_occ) <= cmt_cnt - pop_cnt), 1);
    if (int'(ff_occ) > max_occ) max_occ = int'(ff_occ);
    if (mem_rd_en) begin
      if (first_issue < 0) first_issue = tick_idx;
      n_issue++;
    end
    w = {rd_sop, rd_eop, rd_data};
    if (hold_prev) begin
      check("hold_valid", rd_valid, 1);
      check("hold_data", w, hold_word);
    end
    if (rd_valid) begin
      if (first_valid < 0) first_valid = tick_idx;
      n_valid++;
      last_valid = tick_idx;
      if (rd_ready) begin
        if (exp_q.size() == 0) check("extra_word", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("pop_word", w, e);
          exp_err = e[DW+1] ? m_in_pkt : ~m_in_pkt;
          if (e[DW]) m_in_pkt = 1'b0;
          else if (e[DW+1]) m_in_pkt = 1'b1;
          pop_cnt++;
        end
      end
    end
    hold_prev = rd_valid & ~rd_ready;
    hold_word = w;
    tick_idx++;
    @(negedge clk);
  endtask

  initial begin
    int pk_left, guard, len;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", rd_valid, 0);
    check("rst_empty", ff_empty, 1);
    check("rst_occ", ff_occ, 0);
    check("rst_rptr", rptr_gry, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_data", {rd_sop, rd_eop, rd_data}, 0);
    rst_n = 1'b1;
    clr_stats();
    repeat (8) tick();
    check("idle_issue", n_issue, 0);
    check("idle_empty", ff_empty, 1);
    check("idle_rptr", rptr_gry, 0);

    // One 4-word packet, reader always ready
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) push_word(k == 0, k == 3, $urandom);
    commit();
    clr_stats();
    repeat (12) tick();
    check("p4_issues", n_issue, 4);
    check("p4_sync_lat", 64'(first_issue >= 2 && first_issue <= 3), 1);
    check("p4_rd_lat", first_valid - first_issue, 2);
    check("p4_valid_cnt", n_valid, 4);
    check("p4_valid_run", last_valid - first_valid, 3);
    check("p4_drained", exp_q.size(), 0);
    check("p4_rptr", rptr_gry, gray(4));
    check("p4_empty", ff_empty, 1);

    // Same packet with the reader stalled, then released
    rd_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_word(k == 0, k == 3, $urandom);
    commit();
    clr_stats();
    repeat (12) tick();
    check("stall_issues", n_issue, 2);
    check("stall_valid", rd_valid, 1);
    check("stall_head", {rd_sop, rd_eop, rd_data}, exp_q[0]);
    check("stall_occ", ff_occ, 2);
    rd_ready = 1'b1;
    repeat (8) tick();
    check("rel_issues", n_issue, 4);
    check("rel_drained", exp_q.size(), 0);
    check("rel_popped", pop_cnt, 8);
    check("rel_rptr", rptr_gry, gray(8));

    // Full memory committed at once: occupancy peaks at depth, wrap to zero
    rd_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) push_word(1'b1, 1'b1, $urandom);
    commit();
    clr_stats();
    repeat (10) tick();
    check("full_peak_occ", max_occ, DEPTH);
    check("full_occ", ff_occ, DEPTH - 2);
    check("full_issues", n_issue, 2);
    rd_ready = 1'b1;
    repeat (14) tick();
    check("full_drained", exp_q.size(), 0);
    check("full_occ0", ff_occ, 0);
    check("full_rptr", rptr_gry, gray(cmt_cnt));

    // Random traffic: 20 one-word packets then 15 of 1..3 words, random ready
    pk_left = 35;
    guard = 0;
    clr_stats();
    while ((pk_left > 0 || exp_q.size() > 0) && guard < 3000) begin
      rd_ready = ($urandom_range(0, 3) != 0);
      if (pk_left > 0 && $urandom_range(0, 1) == 1) begin
        len = (pk_left > 15) ? 1 : int'($urandom_range(1, 3));
        if (wr_cnt - pop_cnt + len <= DEPTH) begin
          for (int k = 0; k < len; k++) push_word(k == 0, k == len - 1, $urandom);
          commit();
          pk_left--;
        end
      end
      tick();
      guard++;
    end
    check("rand_done", exp_q.size() + pk_left, 0);
    check("rand_errs", n_err_seen, 0);
    rd_ready = 1'b1;
    repeat (3) tick();
    check("rand_rptr", rptr_gry, gray(cmt_cnt));
    check("rand_empty", ff_empty, 1);
    check("rand_occ", ff_occ, 0);

    // Framing violations: second sop inside a packet, then two bare words
    push_word(1'b1, 1'b0, 32'hA0);
    push_word(1'b1, 1'b0, 32'hB1);
    push_word(1'b0, 1'b1, 32'hC2);
    push_word(1'b0, 1'b0, 32'hD3);
    push_word(1'b0, 1'b1, 32'hE4);
    push_word(1'b1, 1'b1, 32'hF5);
    commit();
    clr_stats();
    repeat (14) tick();
    check("frm_err_cnt", n_err_seen, 3);
    check("frm_drained", exp_q.size(), 0);

    // Reset in the middle of an unload
    rd_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_word(k == 0, k == 3, $urandom);
    commit();
    clr_stats();
    guard = 0;
    while (first_valid < 0 && guard < 10) begin
      tick();
      guard++;
    end
    check("mid_reached", 64'(first_valid >= 0), 1);
    rst_n = 1'b0;
    #1;
    check("mid_valid", rd_valid, 0);
    check("mid_data", {rd_sop, rd_eop, rd_data}, 0);
    check("mid_rd_en", mem_rd_en, 0);
    check("mid_empty", ff_empty, 1);
    check("mid_occ", ff_occ, 0);
    check("mid_err", pkt_err, 0);
    check("mid_rptr", rptr_gry, 0);
    exp_q.delete();
    wr_cnt = 0; cmt_cnt = 0; pop_cnt = 0;
    m_in_pkt = 1'b0; exp_err = 1'b0; hold_prev = 1'b0;
    wptr_cmt_gry = '0;
    @(negedge clk);
    rst_n = 1'b1;
    clr_stats();
    repeat (6) tick();
    check("post_issue", n_issue, 0);
    check("post_empty", ff_empty, 1);
    check("post_valid", rd_valid, 0);
    check("post_rptr", rptr_gry, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
